// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: low-speed USB receive path. It hunts for SYNC, NRZI-decodes and bit-unstuffs the line,
// and assembles LSB-first bytes with EOP and error flags on a UTMI-like byte interface.
package usb_rx_types_pkg;
   typedef enum logic [1:0] {SE0 = 2'b00, J = 2'b01, K = 2'b10, SE1 = 2'b11} d_port_t;
endpackage

module usb_rx_decoder
   import usb_rx_types_pkg::*;
#(
   parameter int MIN_SYNC_ZEROS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       strobe,
   input  d_port_t    q,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_active,
   output logic       rx_error,
   output logic       rx_eop
);
   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, ERR} state_t;
   localparam logic [2:0] MIN_Z = 3'(MIN_SYNC_ZEROS);

   state_t     state, state_n;
   d_port_t    prev_sym, prev_sym_n;
   logic [2:0] zcnt, zcnt_n, ones, ones_n, bitcnt, bitcnt_n;
   logic [7:0] shreg, shreg_n, rx_data_n;
   logic       rx_valid_n, rx_active_n, rx_error_n, rx_eop_n, err_seen, err_seen_n;
   logic       is_data, bit_v, err;

   always_comb begin
      state_n     = state;
      prev_sym_n  = prev_sym;
      zcnt_n      = zcnt;
      ones_n      = ones;
      bitcnt_n    = bitcnt;
      shreg_n     = shreg;
      rx_data_n   = rx_data;
      rx_active_n = rx_active;
      err_seen_n  = err_seen;
      rx_valid_n  = 1'b0;
      rx_error_n  = 1'b0;
      rx_eop_n    = 1'b0;
      err         = 1'b0;
      is_data     = (q == J) || (q == K);
      bit_v       = (q == prev_sym);
      if (strobe) begin
         if (is_data) prev_sym_n = q;
         case (state)
            IDLE: if (q == K) begin
               zcnt_n  = 3'd1;
               state_n = SYNC;
            end
            SYNC: if (is_data && !bit_v) zcnt_n = (zcnt == 3'd7) ? 3'd7 : zcnt + 3'd1;
               else if (is_data && zcnt >= MIN_Z) begin
                  state_n     = DATA;
                  rx_active_n = 1'b1;
                  ones_n      = 3'd1;
                  bitcnt_n    = 3'd0;
                  err_seen_n  = 1'b0;
               end else state_n = IDLE;
            DATA: if (q == SE0) begin
               state_n = EOP1;
               err     = (bitcnt != 3'd0);
            end else if (q == SE1) begin
               state_n = ERR;
               err     = 1'b1;
            end else if (ones == 3'd6) begin
               // ones==6 means this bit is the inserted stuff 0
               if (bit_v) begin
                  state_n = ERR;
                  err     = 1'b1;
               end else ones_n = 3'd0;
            end else begin
               shreg_n  = {bit_v, shreg[7:1]};
               bitcnt_n = bitcnt + 3'd1;
               ones_n   = bit_v ? ones + 3'd1 : 3'd0;
               if (bitcnt == 3'd7) begin
                  rx_data_n  = shreg_n;
                  rx_valid_n = 1'b1;
               end
            end
            EOP1, EOP2: if (q == J) begin
               rx_eop_n    = 1'b1;
               rx_active_n = 1'b0;
               state_n     = IDLE;
            end else if (q == SE0) state_n = EOP2;
               else begin
                  state_n = ERR;
                  err     = 1'b1;
               end
            ERR: if (q == SE0) state_n = EOP1;
            default: state_n = IDLE;
         endcase
         // only the first error of a packet is reported
         rx_error_n = err && !err_seen;
         if (err) err_seen_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         prev_sym  <= J;
         zcnt      <= '0;
         ones      <= '0;
         bitcnt    <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_active <= 1'b0;
         rx_error  <= 1'b0;
         rx_eop    <= 1'b0;
         err_seen  <= 1'b0;
      end else begin
         state     <= state_n;
         prev_sym  <= prev_sym_n;
         zcnt      <= zcnt_n;
         ones      <= ones_n;
         bitcnt    <= bitcnt_n;
         shreg     <= shreg_n;
         rx_data   <= rx_data_n;
         rx_valid  <= rx_valid_n;
         rx_active <= rx_active_n;
         rx_error  <= rx_error_n;
         rx_eop    <= rx_eop_n;
         err_seen  <= err_seen_n;
      end
endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder: table-driven minimal packet, hand-built corner sequences and randomized packets
// produced by a bit-level encoder (stuffing + NRZI) that serves as the reference model.
module tb_usb_rx_decoder;
   import usb_rx_types_pkg::*;

   logic       clk = 1'b0;
   logic       reset, strobe;
   d_port_t    q;
   logic [7:0] rx_data;
   logic       rx_valid, rx_active, rx_error, rx_eop;

   usb_rx_decoder #(.MIN_SYNC_ZEROS(3)) dut (
      .clk(clk), .reset(reset), .strobe(strobe), .q(q), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_active(rx_active), .rx_error(rx_error), .rx_eop(rx_eop)
   );

   always #5 clk = ~clk;

   typedef struct {
      d_port_t    s;
      logic       act, vld;
      logic [7:0] data;
      logic       err, eop;
   } vec_t;

   vec_t       tbl[20];
   d_port_t    syms[20] = '{J, K, J, K, J, K, J, K, K, K, J, J, K, J, J, K, K, SE0, SE0, J};
   int         checks = 0, errors = 0;
   logic [7:0] got[$], want[$];
   int         n_err = 0, n_eop = 0, overlap = 0;
   logic       act_at_err = 1'b0;
   d_port_t    tx[$];
   d_port_t    cur;
   int         ones, nb, drb;
   logic       bad_stuff = 1'b0;
   logic [7:0] b;

   always @(negedge clk) if (reset) begin
      if (rx_valid) got.push_back(rx_data);
      if (rx_error) begin
         n_err++;
         act_at_err = rx_active;
      end
      if (rx_eop) n_eop++;
      if (rx_valid && rx_error) overlap++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic nrzi(input logic bv);
      if (!bv) cur = (cur == J) ? K : J;
      tx.push_back(cur);
   endtask

   task automatic dbit(input logic bv);
      nrzi(bv);
      ones = bv ? ones + 1 : 0;
      if (ones == 6) begin
         nrzi(bad_stuff);
         bad_stuff = 1'b0;
         ones = 0;
      end
   endtask

   task automatic sync(input logic idle);
      if (idle) tx.push_back(J);
      cur = J;
      for (int i = 0; i < 7; i++) nrzi(1'b0);
      nrzi(1'b1);
      ones = 1;
   endtask

   task automatic add_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) dbit(v[i]);
   endtask

   task automatic eop(input logic two);
      tx.push_back(SE0);
      if (two) tx.push_back(SE0);
      tx.push_back(J);
      cur = J;
   endtask

   task automatic play(input int maxgap);
      @(negedge clk);
      while (tx.size() > 0) begin
         q = tx.pop_front();
         strobe = 1'b1;
         @(negedge clk);
         strobe = 1'b0;
         repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_mon();
      got.delete();
      n_err = 0;
      n_eop = 0;
      overlap = 0;
   endtask

   task automatic check_pkt(input string name, input logic [7:0] exp[$], input int e_err, input int e_eop);
      chk({name, " nbytes"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++) chk($sformatf("%s byte%0d", name, i), got[i], exp[i]);
      chk({name, " errors"}, n_err, e_err);
      chk({name, " eops"}, n_eop, e_eop);
      chk({name, " active_end"}, rx_active, 0);
      chk({name, " valid_error_overlap"}, overlap, 0);
      clear_mon();
   endtask

   initial begin
      for (int i = 0; i < 20; i++) begin
         tbl[i].s    = syms[i];
         tbl[i].act  = (i >= 8 && i <= 18);
         tbl[i].vld  = (i == 16);
         tbl[i].data = (i >= 16) ? 8'hA5 : 8'h00;
         tbl[i].err  = 1'b0;
         tbl[i].eop  = (i == 19);
      end
      reset = 1'b0;
      strobe = 1'b0;
      q = J;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {rx_active, rx_valid, rx_data, rx_error, rx_eop}, 0);
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         q = tbl[i].s;
         strobe = 1'b1;
         @(negedge clk);
         strobe = 1'b0;
         chk($sformatf("min_vec%0d", i), {rx_active, rx_valid, rx_data, rx_error, rx_eop},
             {tbl[i].act, tbl[i].vld, tbl[i].data, tbl[i].err, tbl[i].eop});
      end
      repeat (2) @(negedge clk);
      want = '{8'hA5};
      check_pkt("min", want, 0, 1);

      sync(1'b1); add_byte(8'hFF); add_byte(8'h01); eop(1'b1);
      play(1);
      want = '{8'hFF, 8'h01};
      check_pkt("stuff", want, 0, 1);

      sync(1'b1); bad_stuff = 1'b1; add_byte(8'hFF); add_byte(8'h01); eop(1'b1);
      play(1);
      chk("badstuff active_at_err", act_at_err, 1);
      want = {};
      check_pkt("badstuff", want, 1, 1);

      tx = '{J, K, K};
      play(0);
      chk("trunc1 active", rx_active, 0);
      tx = '{K, J, J};
      play(0);
      chk("trunc2 active", rx_active, 0);
      sync(1'b1); add_byte(8'hC3); eop(1'b1);
      play(0);
      want = '{8'hC3};
      check_pkt("trunc_then_full", want, 0, 1);

      tx = '{J, K, J, K, K};
      cur = K;
      ones = 1;
      add_byte(8'h96); eop(1'b0);
      play(0);
      want = '{8'h96};
      check_pkt("min_zeros_sync", want, 0, 1);

      sync(1'b1); add_byte(8'h3C); dbit(1'b1); dbit(1'b0); dbit(1'b1); eop(1'b1);
      play(1);
      want = '{8'h3C};
      check_pkt("dribble", want, 1, 1);

      sync(1'b1); dbit(1'b1); dbit(1'b0); dbit(1'b0); dbit(1'b1);
      tx.push_back(SE1); tx.push_back(K); tx.push_back(J);
      eop(1'b1);
      play(0);
      want = {};
      check_pkt("se1", want, 1, 1);

      sync(1'b1); dbit(1'b1); dbit(1'b0); dbit(1'b1); dbit(1'b1);
      play(0);
      chk("pre_reset active", rx_active, 1);
      #2 reset = 1'b0;
      #1 chk("async_reset_outputs", {rx_active, rx_valid, rx_data, rx_error, rx_eop}, 0);
      @(negedge clk);
      reset = 1'b1;
      clear_mon();
      sync(1'b0); add_byte(8'h5A); eop(1'b1);
      play(0);
      want = '{8'h5A};
      check_pkt("after_reset", want, 0, 1);

      for (int p = 0; p < 25; p++) begin
         nb = $urandom_range(1, 3);
         drb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
         want = {};
         sync(1'b1);
         for (int i = 0; i < nb; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            want.push_back(b);
            add_byte(b);
         end
         for (int i = 0; i < drb; i++) dbit(1'($urandom_range(0, 1)));
         eop(1'($urandom_range(0, 1)));
         play(2);
         check_pkt($sformatf("rand%0d", p), want, (drb != 0) ? 1 : 0, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
